// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style floating-point adder/subtractor with configurable field widths.
// Inputs are flushed to zero, results rounded to nearest-even, specials handled, flags held until the next done.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done,
  output logic                   busy,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   invalid
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int F   = MAN_W + 4;
  localparam int LZW = $clog2(F + 1);
  localparam int EW  = EXP_W + LZW + 2;
  localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4
  } state_t;

  function automatic logic [LZW-1:0] count_lz(input logic [F-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(F);
    for (int i = 0; i < F; i++) begin
      if (v[i]) n = LZW'(F - 1 - i);
    end
    return n;
  endfunction

  state_t                state_r, state_s;
  logic [W-1:0]          op1_r, op2_r;
  logic                  mode_r;
  logic                  sign_r, sub_r;
  logic signed [EW-1:0]  exp_r;
  logic [F-1:0]          ma_r, mb_r, nm_r;
  logic [F:0]            sum_r;
  logic                  spec_r, spec_inv_r;
  logic [W-1:0]          spec_res_r;

  logic                  s1_s, s2_s, z1_s, z2_s, inf1_s, inf2_s, nan1_s, nan2_s, swap_s, sa_s;
  logic [EXP_W-1:0]      e1_s, e2_s, ea_s, eb_s, d_s;
  logic [MAN_W-1:0]      m1_s, m2_s, ma_s, mb_s;
  logic [F-1:0]          fb_s, fb_sh_s, nm_s;
  logic                  spec_s, spec_inv_s;
  logic [W-1:0]          spec_res_s;
  logic [F:0]            sum_s;
  logic [LZW-1:0]        lz_s;
  logic signed [EW-1:0]  exp_n_s, fexp_s;
  logic                  inc_s, inx_s, zero_s;
  logic [MAN_W:0]        rm_s;
  logic [MAN_W-1:0]      man_s;
  logic [W-1:0]          res_s;
  logic                  ovf_s, unf_s, rinx_s, inv_s;

  // Next-state sequencing: every operation walks the full pipeline of states.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_ALIGN;
        else       state_s = S_IDLE;
      end
      S_ALIGN: state_s = S_ADD;
      S_ADD:   state_s = S_NORM;
      S_NORM:  state_s = S_ROUND;
      S_ROUND: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Unpack, classify, order by magnitude and align B; also resolve special operands.
  always_comb begin
    s1_s   = op1_r[W-1];
    e1_s   = op1_r[W-2:MAN_W];
    m1_s   = op1_r[MAN_W-1:0];
    s2_s   = op2_r[W-1] ^ mode_r;
    e2_s   = op2_r[W-2:MAN_W];
    m2_s   = op2_r[MAN_W-1:0];
    z1_s   = (e1_s == {EXP_W{1'b0}});
    z2_s   = (e2_s == {EXP_W{1'b0}});
    inf1_s = (e1_s == EMAX) && (m1_s == {MAN_W{1'b0}});
    inf2_s = (e2_s == EMAX) && (m2_s == {MAN_W{1'b0}});
    nan1_s = (e1_s == EMAX) && (m1_s != {MAN_W{1'b0}});
    nan2_s = (e2_s == EMAX) && (m2_s != {MAN_W{1'b0}});
    swap_s = ({e2_s, m2_s} > {e1_s, m1_s});
    if (swap_s) begin
      sa_s = s2_s; ea_s = e2_s; ma_s = m2_s; eb_s = e1_s; mb_s = m1_s;
    end else begin
      sa_s = s1_s; ea_s = e1_s; ma_s = m1_s; eb_s = e2_s; mb_s = m2_s;
    end
    d_s  = ea_s - eb_s;
    fb_s = {1'b1, mb_s, 3'b000};
    // Bits shifted past S are folded into it so rounding still sees them.
    if (32'(d_s) >= 32'(F)) begin
      fb_sh_s = {{(F-1){1'b0}}, 1'b1};
    end else begin
      fb_sh_s = (fb_s >> d_s) | {{(F-1){1'b0}}, |(fb_s & ~({F{1'b1}} << d_s))};
    end
    spec_s     = 1'b1;
    spec_inv_s = 1'b0;
    spec_res_s = {W{1'b0}};
    if (nan1_s || nan2_s) begin
      spec_res_s = QNAN;
    end else if (inf1_s && inf2_s) begin
      if (s1_s != s2_s) begin
        spec_res_s = QNAN;
        spec_inv_s = 1'b1;
      end else begin
        spec_res_s = {s1_s, EMAX, {MAN_W{1'b0}}};
      end
    end else if (inf1_s) begin
      spec_res_s = {s1_s, EMAX, {MAN_W{1'b0}}};
    end else if (inf2_s) begin
      spec_res_s = {s2_s, EMAX, {MAN_W{1'b0}}};
    end else if (z1_s && z2_s) begin
      spec_res_s = {s1_s & s2_s, {(W-1){1'b0}}};
    end else if (z1_s) begin
      spec_res_s = {s2_s, e2_s, m2_s};
    end else if (z2_s) begin
      spec_res_s = op1_r;
    end else begin
      spec_s = 1'b0;
    end
  end

  // Magnitude add or subtract of the aligned significands.
  always_comb begin
    if (sub_r) sum_s = {1'b0, ma_r} - {1'b0, mb_r};
    else       sum_s = {1'b0, ma_r} + {1'b0, mb_r};
  end

  // Normalise: one right shift on carry, otherwise a single-cycle leading-zero shift.
  always_comb begin
    lz_s = count_lz(sum_r[F-1:0]);
    if (sum_r[F]) begin
      nm_s    = {sum_r[F:2], sum_r[1] | sum_r[0]};
      exp_n_s = exp_r + $signed({{(EW-1){1'b0}}, 1'b1});
    end else begin
      nm_s    = sum_r[F-1:0] << lz_s;
      exp_n_s = exp_r - $signed({{(EW-LZW){1'b0}}, lz_s});
    end
  end

  // Round to nearest-even, then range-check the exponent; a clear hidden bit means an exact zero.
  always_comb begin
    zero_s = ~nm_r[F-1];
    inc_s  = nm_r[2] & (nm_r[1] | nm_r[0] | nm_r[3]);
    inx_s  = nm_r[2] | nm_r[1] | nm_r[0];
    rm_s   = {1'b0, nm_r[F-2:3]} + {{MAN_W{1'b0}}, inc_s};
    fexp_s = exp_r + $signed({{(EW-1){1'b0}}, rm_s[MAN_W]});
    man_s  = rm_s[MAN_W-1:0];
    res_s  = {W{1'b0}};
    ovf_s  = 1'b0;
    unf_s  = 1'b0;
    rinx_s = 1'b0;
    inv_s  = 1'b0;
    if (spec_r) begin
      res_s = spec_res_r;
      inv_s = spec_inv_r;
    end else if (zero_s) begin
      res_s = {W{1'b0}};
    end else if (fexp_s >= $signed({{(EW-EXP_W){1'b0}}, EMAX})) begin
      res_s  = {sign_r, EMAX, {MAN_W{1'b0}}};
      ovf_s  = 1'b1;
      rinx_s = 1'b1;
    end else if (fexp_s <= $signed({EW{1'b0}})) begin
      res_s  = {sign_r, {(W-1){1'b0}}};
      unf_s  = 1'b1;
      rinx_s = 1'b1;
    end else begin
      res_s  = {sign_r, fexp_s[EXP_W-1:0], man_s};
      rinx_s = inx_s;
    end
  end

  // Pipeline registers and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r    <= S_IDLE;
      op1_r      <= {W{1'b0}};
      op2_r      <= {W{1'b0}};
      mode_r     <= 1'b0;
      sign_r     <= 1'b0;
      sub_r      <= 1'b0;
      exp_r      <= {EW{1'b0}};
      ma_r       <= {F{1'b0}};
      mb_r       <= {F{1'b0}};
      nm_r       <= {F{1'b0}};
      sum_r      <= {(F+1){1'b0}};
      spec_r     <= 1'b0;
      spec_inv_r <= 1'b0;
      spec_res_r <= {W{1'b0}};
      result     <= {W{1'b0}};
      done       <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      inexact    <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      state_r <= state_s;
      done    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op1_r  <= op1;
            op2_r  <= op2;
            mode_r <= mode;
            busy   <= 1'b1;
          end
        end
        S_ALIGN: begin
          sign_r     <= sa_s;
          sub_r      <= s1_s ^ s2_s;
          exp_r      <= $signed({{(EW-EXP_W){1'b0}}, ea_s});
          ma_r       <= {1'b1, ma_s, 3'b000};
          mb_r       <= fb_sh_s;
          spec_r     <= spec_s;
          spec_inv_r <= spec_inv_s;
          spec_res_r <= spec_res_s;
        end
        S_ADD: begin
          sum_r <= sum_s;
          if (sum_s == {(F+1){1'b0}}) sign_r <= 1'b0;
        end
        S_NORM: begin
          nm_r  <= nm_s;
          exp_r <= exp_n_s;
        end
        S_ROUND: begin
          result    <= res_s;
          overflow  <= ovf_s;
          underflow <= unf_s;
          inexact   <= rinx_s;
          invalid   <= inv_s;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: single-precision and half-precision instances,
// expectations queued at start and compared on each done pulse.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        n_rst, start, mode, start_h, mode_h;
  logic [31:0] op1, op2, result;
  logic [15:0] op1_h, op2_h, result_h;
  logic        done, busy, overflow, underflow, inexact, invalid;
  logic        done_h, busy_h, ovf_h, unf_h, inx_h, inv_h;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  flg;
    int          t0;
  } exp_t;

  exp_t q_s[$];
  exp_t q_h[$];
  exp_t e_s, e_h;
  int   n_cmp = 0, n_err = 0, cycle = 0, n_done = 0, n_done_h = 0;
  logic done_d = 1'b0, done_h_d = 1'b0;

  fp_addsub_seq dut (
    .clk(clk), .n_rst(n_rst), .start(start), .mode(mode), .op1(op1), .op2(op2),
    .result(result), .done(done), .busy(busy), .overflow(overflow),
    .underflow(underflow), .inexact(inexact), .invalid(invalid)
  );

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .n_rst(n_rst), .start(start_h), .mode(mode_h), .op1(op1_h), .op2(op2_h),
    .result(result_h), .done(done_h), .busy(busy_h), .overflow(ovf_h),
    .underflow(unf_h), .inexact(inx_h), .invalid(inv_h)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      check_value("done_consecutive", 64'(done_d), 64'd0);
      check_value("done_pending", 64'(q_s.size() > 0), 64'd1);
      if (q_s.size() > 0) begin
        e_s = q_s.pop_front();
        check_value({e_s.tag, "_result"}, 64'(result), 64'(e_s.res));
        check_value({e_s.tag, "_flags"}, 64'({overflow, underflow, inexact, invalid}), 64'(e_s.flg));
        check_value({e_s.tag, "_latency"}, 64'(cycle - e_s.t0), 64'd4);
      end
    end
    done_d <= done;
  end

  always @(negedge clk) begin
    if (done_h === 1'b1) begin
      n_done_h++;
      check_value("h_done_consecutive", 64'(done_h_d), 64'd0);
      check_value("h_done_pending", 64'(q_h.size() > 0), 64'd1);
      if (q_h.size() > 0) begin
        e_h = q_h.pop_front();
        check_value({e_h.tag, "_result"}, 64'(result_h), 64'(e_h.res));
        check_value({e_h.tag, "_flags"}, 64'({ovf_h, unf_h, inx_h, inv_h}), 64'(e_h.flg));
        check_value({e_h.tag, "_latency"}, 64'(cycle - e_h.t0), 64'd4);
      end
    end
    done_h_d <= done_h;
  end

  // flags argument order: {overflow, underflow, inexact, invalid}
  task automatic run_s(input string tag, input logic [31:0] a, input logic [31:0] b, input logic m,
                       input logic [31:0] r, input logic [3:0] f, input int hold);
    exp_t e;
    int   k;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check_value({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    op1 = a; op2 = b; mode = m; start = 1'b1;
    e.tag = tag; e.res = r; e.flg = f; e.t0 = cycle + 1;
    q_s.push_back(e);
    @(negedge clk);
    check_value({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      op1 = $urandom; op2 = $urandom; mode = ~mode;
      @(negedge clk);
    end
    start = 1'b0;
    op1 = $urandom; op2 = $urandom; mode = ~mode;
  endtask

  task automatic run_h(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [15:0] r, input logic [3:0] f);
    exp_t e;
    int   k;
    k = 0;
    while (busy_h !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check_value({tag, "_idle_timeout"}, 64'(busy_h), 64'd0);
    op1_h = a; op2_h = b; mode_h = m; start_h = 1'b1;
    e.tag = tag; e.res = {16'h0000, r}; e.flg = f; e.t0 = cycle + 1;
    q_h.push_back(e);
    @(negedge clk);
    start_h = 1'b0;
    op1_h = 16'($urandom); op2_h = 16'($urandom);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((q_s.size() > 0 || q_h.size() > 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) check_value({tag, "_drain_timeout"}, 64'(q_s.size() + q_h.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0;
    n_rst = 1'b0; start = 1'b0; mode = 1'b0; op1 = 32'h0; op2 = 32'h0;
    start_h = 1'b0; mode_h = 1'b0; op1_h = 16'h0; op2_h = 16'h0;
    repeat (3) @(negedge clk);
    check_value("rst_result", 64'(result), 64'd0);
    check_value("rst_done_busy", 64'({done, busy}), 64'd0);
    check_value("rst_flags", 64'({overflow, underflow, inexact, invalid}), 64'd0);
    check_value("rst_h_result", 64'(result_h), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    run_s("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 0);
    run_s("sub_basic",     32'h3FC00000, 32'h3E800000, 1'b1, 32'h3FA00000, 4'b0000, 0);
    run_s("sub_exact_zero",32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 0);
    run_s("cancel",        32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000, 0);
    run_s("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010, 0);
    run_s("tie_odd",       32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0010, 0);
    run_s("round_carry",   32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0010, 0);
    run_s("mixed_sign",    32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'b0000, 0);
    run_s("far_sticky",    32'h4F800000, 32'h3F800000, 1'b0, 32'h4F800000, 4'b0010, 0);
    run_s("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010, 0);
    run_s("round_ovf",     32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b1010, 0);
    run_s("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001, 0);
    run_s("underflow",     32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0110, 0);
    run_s("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 0);
    run_s("inf_plus_fin",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 0);
    run_s("negz_plus_negz",32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 0);
    run_s("negz_minus_negz",32'h80000000,32'h80000000, 1'b1, 32'h00000000, 4'b0000, 0);
    run_s("zero_minus_x",  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 0);
    run_s("x_plus_zero",   32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 4'b0000, 0);
    run_s("denorm_flush",  32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 0);
    drain("basic");

    nd0 = n_done;
    run_s("busy_ignore",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 3);
    drain("ignore");
    repeat (6) @(negedge clk);
    check_value("ignore_single_done", 64'(n_done - nd0), 64'd1);
    check_value("result_hold", 64'(result), 64'h40400000);

    // abort an operation in its second cycle; no expectation is queued for it
    nd0 = n_done;
    op1 = 32'h3F800000; op2 = 32'h3F800000; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check_value("abort_result", 64'(result), 64'd0);
    check_value("abort_done_busy", 64'({done, busy}), 64'd0);
    check_value("abort_flags", 64'({overflow, underflow, inexact, invalid}), 64'd0);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    check_value("abort_no_done", 64'(n_done - nd0), 64'd0);
    run_s("after_abort",   32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 0);
    drain("abort");

    run_h("h_one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
    run_h("h_overflow",     16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b1010);
    run_h("h_sub_zero",     16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
    run_h("h_tie_even",     16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0010);
    drain("half");
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
